// File: rtl/booth_radix4_seq_mult.sv
// -----------------------------------------------------------------------------
// booth_radix4_seq_mult
//   Iterative radix-4 Booth multiplier. Each busy cycle retires
//   DIGITS_PER_CYCLE Booth digits into a carry-propagate accumulator.
//   Operands and signedness are captured on the input handshake. The exact
//   2*WIDTH-bit product is held on Product_DO while Out_Valid_SO is high.
//
// Parameters
//   WIDTH             operand width (even, >= 4)
//   DIGITS_PER_CYCLE  Booth digits retired per busy cycle (1..WIDTH/2+1)
//
// Ports
//   Clk_CI        clock
//   Rst_RI        synchronous active-high reset
//   In_Valid_SI   operands valid
//   In_Ready_SO   block can accept operands (IDLE)
//   Signed_SI     1: two's-complement operands, 0: unsigned
//   Op_a_DI       multiplicand
//   Op_b_DI       multiplier (Booth recoded)
//   Kill_SI       abort current operation / block accept in IDLE
//   Out_Valid_SO  product valid (DONE)
//   Out_Ready_SI  consumer accepts product
//   Product_DO    exact product
//
// Optional feature
//   BOOTH_SEQ_EARLY_TERM_EN: when defined, the block finishes as soon as all
//   not-yet-retired multiplier bits are identical (remaining digits are zero).
// -----------------------------------------------------------------------------
module booth_radix4_seq_mult #(
  parameter int WIDTH            = 24,
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RI,
  input  logic                 In_Valid_SI,
  output logic                 In_Ready_SO,
  input  logic                 Signed_SI,
  input  logic [WIDTH-1:0]     Op_a_DI,
  input  logic [WIDTH-1:0]     Op_b_DI,
  input  logic                 Kill_SI,
  output logic                 Out_Valid_SO,
  input  logic                 Out_Ready_SI,
  output logic [2*WIDTH-1:0]   Product_DO
);

  localparam int ND = WIDTH / 2 + 1;      // Booth digit count
  localparam int EW = WIDTH + 2;          // extended operand width
  localparam int AW = 2 * WIDTH + 4;      // accumulator width
  localparam int CW = $clog2(ND + DIGITS_PER_CYCLE + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [EW-1:0]   a_q, a_d;
  // Multiplier with b[-1] appended at bit 0: b[k] lives at b_q[k+1].
  logic [EW:0]     b_q, b_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [AW-1:0]   acc_step;
  logic [CW-1:0]   cnt_next;
  logic            finished;
  logic [2:0]      triplet;
  int              idx;
`ifdef BOOTH_SEQ_EARLY_TERM_EN
  logic            rest_uniform;
`endif

  // Sign- or zero-extend an operand to WIDTH+2 bits.
  function automatic logic [EW-1:0] ext_op(input logic [WIDTH-1:0] v, input logic s);
    return {{2{s & v[WIDTH-1]}}, v};
  endfunction

  // Partial product of one Booth digit, already shifted to its weight 4^i.
  function automatic logic [AW-1:0] booth_pp(input logic [2:0] t,
                                             input logic [EW-1:0] a,
                                             input int shamt);
    logic          sel1x;
    logic          sel2x;
    logic          neg;
    logic [AW-1:0] a_ext;
    logic [AW-1:0] mag;
    logic [AW-1:0] pp;
    sel1x = t[1] ^ t[0];
    sel2x = ~(sel1x | ~(t[2] ^ t[1]));
    neg   = t[2];
    a_ext = {{(AW-EW){a[EW-1]}}, a};
    if (sel1x) begin
      mag = a_ext;
    end else if (sel2x) begin
      mag = a_ext << 1;
    end else begin
      mag = {AW{1'b0}};
    end
    if (neg) begin
      pp = ~mag + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      pp = mag;
    end
    return pp << shamt;
  endfunction

  // Retire this cycle's digit group into a candidate accumulator value.
  always_comb begin
    acc_step = acc_q;
    triplet  = 3'b000;
    idx      = 0;
    for (int j = 0; j < DIGITS_PER_CYCLE; j++) begin
      idx = int'(cnt_q) + j;
      if (idx < ND) begin
        triplet  = 3'(b_q >> (2 * idx));
        acc_step = acc_step + booth_pp(triplet, a_q, 2 * idx);
      end else begin
        acc_step = acc_step;
      end
    end
    cnt_next = cnt_q + CW'(DIGITS_PER_CYCLE);
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    // Remaining bits b[WIDTH+1:2k-1] sit at b_q[EW:2k]; all equal => zero digits.
    rest_uniform = 1'b1;
    for (int m = 0; m <= EW; m++) begin
      if ((m >= 2 * int'(cnt_next)) && (b_q[m] != b_q[EW])) begin
        rest_uniform = 1'b0;
      end else begin
        rest_uniform = rest_uniform;
      end
    end
    finished = (int'(cnt_next) >= ND) || rest_uniform;
`else
    finished = (int'(cnt_next) >= ND);
`endif
  end

  // Next-state, datapath update and registered handshake outputs.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (Kill_SI) begin
          state_d = S_IDLE;
        end else if (In_Valid_SI) begin
          a_d     = ext_op(Op_a_DI, Signed_SI);
          b_d     = {ext_op(Op_b_DI, Signed_SI), 1'b0};
          acc_d   = {AW{1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (Kill_SI) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_next;
          if (finished) begin
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_DONE: begin
        // Accumulator is not touched here so the product stays stable.
        if (Kill_SI || Out_Ready_SI) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q     <= S_IDLE;
      a_q         <= {EW{1'b0}};
      b_q         <= {(EW+1){1'b0}};
      acc_q       <= {AW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign In_Ready_SO  = in_ready_q;
  assign Out_Valid_SO = out_valid_q;
  assign Product_DO   = acc_q[2*WIDTH-1:0];

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// -----------------------------------------------------------------------------
// tb_booth_radix4_seq_mult
//   Self-checking bench for booth_radix4_seq_mult. Three instances share the
//   stimulus bus: WIDTH=8/DPC=1, WIDTH=24/DPC=4 and WIDTH=24/DPC=1; `sel`
//   chooses which one receives In_Valid_SI and is observed. Expected
//   products and latencies come from plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_booth_radix4_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        signed_i;
  logic        kill;
  logic        out_ready;
  logic [23:0] op_a;
  logic [23:0] op_b;
  int          sel;

  logic        rdy0, rdy1, rdy2;
  logic        vld0, vld1, vld2;
  logic [15:0] prod0;
  logic [47:0] prod1, prod2;

  logic        in_ready_m;
  logic        out_valid_m;
  logic [47:0] product_m;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  booth_radix4_seq_mult #(.WIDTH(8), .DIGITS_PER_CYCLE(1)) u_w8 (
    .Clk_CI(clk), .Rst_RI(rst), .In_Valid_SI(in_valid && (sel == 0)),
    .In_Ready_SO(rdy0), .Signed_SI(signed_i), .Op_a_DI(op_a[7:0]),
    .Op_b_DI(op_b[7:0]), .Kill_SI(kill), .Out_Valid_SO(vld0),
    .Out_Ready_SI(out_ready), .Product_DO(prod0));

  booth_radix4_seq_mult #(.WIDTH(24), .DIGITS_PER_CYCLE(4)) u_w24d4 (
    .Clk_CI(clk), .Rst_RI(rst), .In_Valid_SI(in_valid && (sel == 1)),
    .In_Ready_SO(rdy1), .Signed_SI(signed_i), .Op_a_DI(op_a),
    .Op_b_DI(op_b), .Kill_SI(kill), .Out_Valid_SO(vld1),
    .Out_Ready_SI(out_ready), .Product_DO(prod1));

  booth_radix4_seq_mult #(.WIDTH(24), .DIGITS_PER_CYCLE(1)) u_w24d1 (
    .Clk_CI(clk), .Rst_RI(rst), .In_Valid_SI(in_valid && (sel == 2)),
    .In_Ready_SO(rdy2), .Signed_SI(signed_i), .Op_a_DI(op_a),
    .Op_b_DI(op_b), .Kill_SI(kill), .Out_Valid_SO(vld2),
    .Out_Ready_SI(out_ready), .Product_DO(prod2));

  // Observe the selected instance.
  always_comb begin
    case (sel)
      0: begin in_ready_m = rdy0; out_valid_m = vld0; product_m = {32'd0, prod0}; end
      1: begin in_ready_m = rdy1; out_valid_m = vld1; product_m = prod1; end
      default: begin in_ready_m = rdy2; out_valid_m = vld2; product_m = prod2; end
    endcase
  end

  // Operand value as a mathematical integer (w-bit, signed or unsigned).
  function automatic longint op_val(input int w, input logic [23:0] v, input bit sg);
    longint x;
    x = longint'(v) & ((longint'(1) << w) - 1);
    if (sg && x[w-1]) x = x - (longint'(1) << w);
    return x;
  endfunction

  function automatic logic [47:0] ref_prod(input int w, input logic [23:0] a,
                                           input logic [23:0] b, input bit sg);
    longint p;
    p = op_val(w, a, sg) * op_val(w, b, sg);
    return 48'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Edges from accept to Out_Valid_SO.
  function automatic int exp_lat(input int w, input int dpc, input logic [23:0] b, input bit sg);
    int     nd;
    int     nc;
    longint bx;
    bit     uni;
    nd = w / 2 + 1;
    nc = (nd + dpc - 1) / dpc;
    bx = op_val(w, b, sg) <<< 1;
    uni = 1'b0;
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    for (int k = 1; k <= nc; k++) begin
      if (k * dpc >= nd) return k;
      uni = 1'b1;
      for (int m = 2 * k * dpc; m <= w + 2; m++)
        if (bx[m] != bx[w+2]) uni = 1'b0;
      if (uni) return k;
    end
`endif
    return nc + (uni ? 0 : 0) + (bx == bx ? 0 : 0);
  endfunction

  function automatic int width_of(input int s);
    return (s == 0) ? 8 : 24;
  endfunction

  function automatic int dpc_of(input int s);
    return (s == 1) ? 4 : 1;
  endfunction

  // Accept one operation and wait (bounded) until Out_Valid_SO.
  task automatic do_op(input int s, input logic [23:0] a, input logic [23:0] b,
                       input bit sg, output logic [47:0] p, output int lat);
    sel = s; op_a = a; op_b = b; signed_i = sg; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready_m !== 1'b1) begin
      failures++;
      $display("FAIL accept_ready: in_ready=%b expected 1", in_ready_m);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = 24'($urandom); op_b = 24'($urandom); signed_i = ~sg;
    lat = 0;
    while (out_valid_m !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    p = product_m;
  endtask

  // Output handshake; the block must be idle one edge later.
  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0) begin
      failures++;
      $display("FAIL release_idle: ready=%b valid=%b expected 1/0", in_ready_m, out_valid_m);
    end
  endtask

  task automatic check_op(input string nm, input int s, input logic [23:0] a,
                          input logic [23:0] b, input bit sg);
    logic [47:0] p;
    int          lat;
    do_op(s, a, b, sg, p, lat);
    checks++;
    if (p !== ref_prod(width_of(s), a, b, sg)) begin
      failures++;
      $display("FAIL %s_product: got %0h expected %0h", nm, p, ref_prod(width_of(s), a, b, sg));
    end
    checks++;
    if (lat !== exp_lat(width_of(s), dpc_of(s), b, sg)) begin
      failures++;
      $display("FAIL %s_latency: got %0d expected %0d", nm, lat, exp_lat(width_of(s), dpc_of(s), b, sg));
    end
    release_out();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      checks++;
      if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0 || product_m !== 48'd0) begin
        failures++;
        $display("FAIL reset_state[%0d]: ready=%b valid=%b prod=%0h expected 1/0/0",
                 s, in_ready_m, out_valid_m, product_m);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed8();
    logic [47:0] p;
    int          lat;
    do_op(0, 24'h80, 24'h80, 1'b1, p, lat);
    checks++;
    if (p !== 48'h4000) begin failures++; $display("FAIL min_sq: got %0h expected 4000", p); end
    checks++;
    if (lat !== exp_lat(8, 1, 24'h80, 1'b1)) begin
      failures++; $display("FAIL min_sq_lat: got %0d expected %0d", lat, exp_lat(8, 1, 24'h80, 1'b1));
    end
    release_out();
    do_op(0, 24'hFF, 24'hFF, 1'b0, p, lat);
    checks++;
    if (p !== 48'hFE01) begin failures++; $display("FAIL ff_unsigned: got %0h expected fe01", p); end
    release_out();
    do_op(0, 24'hFF, 24'hFF, 1'b1, p, lat);
    checks++;
    if (p !== 48'h0001) begin failures++; $display("FAIL ff_signed: got %0h expected 1", p); end
    release_out();
  endtask

  task automatic test_backpressure();
    logic [47:0] p;
    int          lat;
    do_op(0, 24'h03, 24'hFB, 1'b1, p, lat);
    checks++;
    if (p !== 48'hFFF1) begin failures++; $display("FAIL bp_product: got %0h expected fff1", p); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; op_a = 24'($urandom); op_b = 24'($urandom);
      @(posedge clk); #1;
      checks++;
      if (product_m !== 48'hFFF1 || out_valid_m !== 1'b1 || in_ready_m !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: prod=%0h valid=%b ready=%b expected fff1/1/0",
                 i, product_m, out_valid_m, in_ready_m);
      end
    end
    in_valid = 1'b0;
    release_out();
  endtask

  task automatic test_random24();
    logic [23:0] corner [5];
    logic [23:0] a;
    logic [23:0] b;
    corner[0] = 24'h000000; corner[1] = 24'h800000; corner[2] = 24'h7FFFFF;
    corner[3] = 24'hFFFFFF; corner[4] = 24'h000001;
    for (int i = 0; i < 1000; i++) begin
      a = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 4)] : 24'($urandom);
      b = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 4)] : 24'($urandom);
      check_op("rand24", 1, a, b, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++)
      check_op("b2b8", 0, 24'($urandom), 24'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_kill_reset();
    int saw_valid;
    // Kill has priority over a valid in IDLE.
    sel = 0; kill = 1'b1; in_valid = 1'b1; op_a = 24'h11; op_b = 24'h55;
    @(posedge clk); #1;
    kill = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready_m !== 1'b1) begin failures++; $display("FAIL kill_idle: ready=%b expected 1", in_ready_m); end
    // Kill on the second BUSY edge.
    in_valid = 1'b1; op_a = 24'h11; op_b = 24'h55; signed_i = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1; kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    checks++;
    if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0) begin
      failures++; $display("FAIL kill_busy: ready=%b valid=%b expected 1/0", in_ready_m, out_valid_m);
    end
    saw_valid = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid_m === 1'b1) saw_valid++; end
    checks++;
    if (saw_valid != 0) begin failures++; $display("FAIL kill_no_valid: valid cycles=%0d expected 0", saw_valid); end
    // Reset mid-BUSY.
    in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    checks++;
    if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0 || product_m !== 48'd0) begin
      failures++; $display("FAIL reset_busy: ready=%b valid=%b prod=%0h expected 1/0/0",
                           in_ready_m, out_valid_m, product_m);
    end
    saw_valid = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid_m === 1'b1) saw_valid++; end
    checks++;
    if (saw_valid != 0) begin failures++; $display("FAIL reset_no_valid: valid cycles=%0d expected 0", saw_valid); end
    check_op("after_abort", 0, 24'd7, 24'd9, 1'b0);
  endtask

  task automatic test_kill_done();
    logic [47:0] p;
    int          lat;
    do_op(2, 24'h000123, 24'h000456, 1'b0, p, lat);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checks++;
    if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1) begin
      failures++; $display("FAIL kill_done: valid=%b ready=%b expected 0/1", out_valid_m, in_ready_m);
    end
  endtask

  task automatic test_early_term();
    logic [47:0] p;
    int          lat;
    int          want;
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    want = 2;
`else
    want = 13;
`endif
    do_op(2, 24'h000005, 24'h000003, 1'b0, p, lat);
    checks++;
    if (p !== 48'h00000F) begin failures++; $display("FAIL et_product: got %0h expected f", p); end
    checks++;
    if (lat !== want) begin failures++; $display("FAIL et_latency: got %0d expected %0d", lat, want); end
    release_out();
    for (int i = 0; i < 40; i++)
      check_op("rand24d1", 2, 24'($urandom), 24'($urandom >> $urandom_range(0, 23)),
               1'($urandom_range(0, 1)));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; signed_i = 1'b0; kill = 1'b0; out_ready = 1'b0;
    op_a = 24'd0; op_b = 24'd0; sel = 0;
    test_reset();
    test_directed8();
    test_backpressure();
    test_kill_reset();
    test_kill_done();
    test_back_to_back();
    test_early_term();
    test_random24();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_radix4_seq_mult.md
Name: booth_radix4_seq_mult

Overview:
Iterative radix-4 Booth multiplier for the fmac mantissa path. Each cycle it retires a parametrised number of Booth digits into a carry-propagate accumulator. The block supports signed and unsigned operands and uses valid/ready handshakes on both sides. It replaces a fully parallel partial-product array where area matters more than latency (divider/sqrt companions, low-area FPU configs).

Parameters:
WIDTH, 24, operand width in bits; must be even and >= 4
DIGITS_PER_CYCLE, 1, Booth digits retired per busy cycle; 1..WIDTH/2+1

Ports:
Clk_CI  input  1  clock
Rst_RI  input  1  synchronous active-high reset
In_Valid_SI  input  1  operands valid
In_Ready_SO  output  1  block can accept operands
Signed_SI  input  1  1: two's-complement operands; 0: unsigned
Op_a_DI  input  WIDTH  multiplicand
Op_b_DI  input  WIDTH  multiplier (Booth-recoded)
Kill_SI  input  1  abort current operation
Out_Valid_SO  output  1  product valid
Out_Ready_SI  input  1  consumer accepts product
Product_DO  output  2*WIDTH  exact product, signed or unsigned per captured mode

Behaviour:
- One clock, Clk_CI; reset Rst_RI is synchronous and active-high.
- Reset: state IDLE, In_Ready_SO=1, Out_Valid_SO=0, Product_DO=0, accumulator=0, digit counter=0.
- Digit count ND = WIDTH/2+1; busy cycles NC = ceil(ND/DIGITS_PER_CYCLE).
- Operand extension, captured on accept:
  - A extends to WIDTH+2 bits: sign-extended if Signed_SI=1, else zero-extended.
  - B extends to WIDTH+2 bits the same way, with an implicit b[-1]=0 appended.
- Digit i uses triplet t=b[2i+1:2i-1]:
  - sel1x = t[1]^t[0]
  - sel2x = ~(sel1x | ~(t[2]^t[1]))
  - neg = t[2]
  - pp = neg ? -(sel1x?A:sel2x?2A:0) : (sel1x?A:sel2x?2A:0)
  - pp is sign-extended and added at weight 4^i.
- Accumulator width 2*WIDTH+4. Product_DO = accumulator[2*WIDTH-1:0]; the result is exact in both modes.
- FSM IDLE / BUSY / DONE:
  - IDLE: In_Ready_SO=1. On an edge with In_Valid_SI=1, capture operands and mode, clear accumulator and counter, go to BUSY.
  - BUSY: In_Ready_SO=0. Each edge retires digits [k*DPC, min((k+1)*DPC, ND)-1], in order, within one edge. The edge that retires digit ND-1 goes to DONE.
  - DONE: Out_Valid_SO=1; Product_DO holds stable. On an edge with Out_Ready_SI=1, go to IDLE.
- Latency: Out_Valid_SO asserts exactly NC edges after the accepting edge. No overlap between jobs; a new accept happens at earliest one edge after the output handshake.
- Input changes while not in IDLE are ignored.
- Kill_SI: in BUSY or DONE, the next edge goes to IDLE and Out_Valid_SO=0; no product is delivered. In IDLE, Kill_SI has priority over In_Valid_SI (no accept).
- Reset has priority over all events, including mid-BUSY and a pending DONE output.
- Out_Ready_SI in IDLE or BUSY has no effect.

Optional Feature:
- Macro: BOOTH_SEQ_EARLY_TERM_EN.
- Defined: at each BUSY edge, if all not-yet-retired multiplier bits b[WIDTH+1:2k-1] are identical, every remaining digit is 0.
  - The block then goes to DONE on that edge.
  - That edge still adds any digits it retires; the result is unchanged.
  - Latency becomes variable, 1..NC edges.
- Undefined: fixed NC-edge latency; no detection logic present.

Test Plan:
- WIDTH=8, DPC=1, signed, A=0x80, B=0x80 -> Product_DO=0x4000; Out_Valid_SO exactly 5 edges after accept.
- WIDTH=8, unsigned, A=0xFF, B=0xFF -> 0xFE01; same operands signed -> 0x0001.
- WIDTH=8, signed, A=0x03, B=0xFB (-5) -> 0xFFF1. Hold Out_Ready_SI=0 for 4 cycles: Product_DO and Out_Valid_SO stable, In_Ready_SO=0; accept on release; IDLE next edge.
- WIDTH=24, DPC=4, 1000 random signed/unsigned pairs -> match reference product; latency always 4 edges.
- Kill_SI asserted on 2nd BUSY edge, and Rst_RI asserted mid-BUSY -> IDLE next edge, Out_Valid_SO never rises, next op (A=7, B=9 unsigned) -> 0x003F.
- With BOOTH_SEQ_EARLY_TERM_EN, WIDTH=24, DPC=1, B=0x000003 unsigned, A=0x000005 -> 0x00000F after 2 edges. Without the macro, same operands -> 0x00000F after 13 edges.
